bcd_display_ctrl: RTL and testbench
===================================

// Module: bcd_display_ctrl
// PURPOSE
//   Upstream feeder for the per-digit hex_to_7segment decoders on the board 7-seg bank.
//   Accepts a binary value (frame count / debug counter) via valid/ready handshake.
//   Converts it to decimal with an iterative double-dabble engine.
//   Presents DIGITS registered BCD nibbles plus a per-digit blank mask; top level forces blanked digits' segments off.
// PARAMETERS
//   BIN_W   20  width of input binary value (1..32)
//   DIGITS  6   number of BCD digits / displays driven (1..9); MAX = 10**DIGITS-1 (localparam)
// PORTS
//   clk          in   1          system clock; all state updates on rising edge
//   reset        in   1          synchronous, active-high reset
//   in_value     in   BIN_W      binary value to display
//   in_valid     in   1          in_value is valid this cycle
//   in_ready     out  1          converter idle; transfer occurs when in_valid && in_ready
//   digits       out  4*DIGITS   BCD nibbles, [3:0] = least-significant digit; each nibble 0..9
//   digit_blank  out  DIGITS     1 = digit must be displayed blank
//   overflow     out  1          last accepted value exceeded MAX
//   update_done  out  1          one-cycle pulse when digits/digit_blank/overflow change
// BEHAVIOUR
//   Reset (while reset=1, next edge): state=IDLE, digits=0, overflow=0, update_done=0,
//     digit_blank = reset-blank mask (see CONFIGURATION); in_ready=0 while reset is high.
//   Handshake: in_ready = (state==IDLE) && !reset, combinational from state.
//     in_value is captured on the accept edge; in_valid while not ready is ignored (not queued).
//   FSM: IDLE -> SHIFT on accept with in_value <= MAX; IDLE -> UPDATE on accept with in_value > MAX;
//     SHIFT -> UPDATE after BIN_W shift cycles; UPDATE -> IDLE unconditionally.
//   SHIFT cycle (BIN_W cycles, down-counter BIN_W-1..0):
//     - add 3 to each working BCD nibble >= 5;
//     - then shift {bcd, bin} left by 1; bin MSB enters bcd LSB.
//     - Working BCD reg is 4*DIGITS bits wide, cleared on accept; no nibble can exceed 9 because in_value <= MAX.
//   Overflow path: on accept, working BCD is preloaded to all 9s, ovf flag set; SHIFT skipped.
//   UPDATE cycle: next edge loads digits <= working BCD, overflow <= ovf flag, digit_blank <= computed mask,
//     and update_done = 1 for exactly that one following cycle.
//   Latency (accept edge = E0): normal outputs change on edge E(BIN_W+1); overflow outputs change on edge E1.
//     in_ready returns high in the cycle after the output-load edge; max throughput 1 value per BIN_W+2 cycles.
//   Outputs hold previous value for the whole conversion (no intermediate/flicker values).
//   Reset mid-conversion: conversion aborted, outputs return to reset values, no update_done pulse.
//   Boundaries: in_value=0 -> all-zero digits; in_value=MAX -> all 9s with overflow=0;
//     values with bits above MAX -> overflow=1.
// CONFIGURATION
//   LZ_BLANK_EN defined:
//     - Leading-zero suppression: digit_blank[i]=1 for every digit above the most-significant nonzero digit.
//     - digit_blank[0] is never set (value 0 shows single "0").
//     - Overflow: mask = 0.
//     - Reset mask = {DIGITS-1 ones, 0}.
//   LZ_BLANK_EN undefined: digit_blank is constant 0 (reset included); all digits always shown.
// TESTING (BIN_W=20, DIGITS=6)
//   1. in_value=123456 accepted at E0 -> digits=24'h123456 on E21, update_done high one cycle, overflow=0, blank=0.
//   2. in_value=0 -> digits=0; LZ_BLANK_EN: blank=6'b111110, else 0; in_value=42 -> LZ: blank=6'b111100.
//   3. in_value=999999 -> digits=24'h999999, overflow=0; then 1000000 -> overflow=1, digits=24'h999999,
//      outputs on E1, blank=0.
//   4. in_valid held high continuously with 5,6,7 -> exactly one accept per 22 cycles; outputs 5,6,7 in order;
//      in_ready low during SHIFT.
//   5. reset asserted at SHIFT cycle 10 -> digits=0, no update_done; next accept of 77 converts correctly
//      (24'h000077).
//   6. Random in_value stream vs decimal model -> digits/overflow/blank match after every update_done.

Source files
------------

// File: rtl/bcd_display_ctrl_if.sv
// Handshake and display bus between a binary-value producer and bcd_display_ctrl.
// master drives in_value/in_valid; slave (the converter) drives ready and display outputs.
interface bcd_display_ctrl_if #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
);
  logic [BIN_W-1:0]    in_value;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   digit_blank;
  logic                overflow;
  logic                update_done;

  modport master (
    output in_value,
    output in_valid,
    input  in_ready,
    input  digits,
    input  digit_blank,
    input  overflow,
    input  update_done
  );

  modport slave (
    input  in_value,
    input  in_valid,
    output in_ready,
    output digits,
    output digit_blank,
    output overflow,
    output update_done
  );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD feeder for the 7-seg bank: iterative double-dabble with registered outputs.
// Optional macro LZ_BLANK_EN enables leading-zero blanking of the digit_blank mask.
module bcd_display_ctrl #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic               clk,
  input  logic               reset,
  bcd_display_ctrl_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

`ifdef LZ_BLANK_EN
  localparam logic [DIGITS-1:0] RST_MASK = {DIGITS{1'b1}} ^ DIGITS'(1);
`else
  localparam logic [DIGITS-1:0] RST_MASK = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_UPDATE
  } state_t;

  state_t            r_state;
  logic [BIN_W-1:0]  r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic [BCD_W-1:0]  r_digits;
  logic [DIGITS-1:0] r_blank;
  logic              r_overflow;
  logic              r_update_done;

  logic              w_ready;
  logic              w_accept;
  logic              w_over;
  logic [BCD_W-1:0]  w_adj;
  logic [DIGITS-1:0] w_blank_next;

  assign w_ready  = (r_state == S_IDLE) && !reset;
  assign w_accept = bus.in_valid && w_ready;
  assign w_over   = (64'(bus.in_value) > MAX_VAL);

  // Add-3 correction applied to every nibble before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
    end
  endgenerate

`ifdef LZ_BLANK_EN
  // Digit gi is blank when it and every digit above it are zero; digit 0 always shows.
  logic [DIGITS-1:0] w_lz_mask;
  assign w_lz_mask[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign w_lz_mask[gi] = ~|r_bcd[BCD_W-1:4*gi];
    end
  endgenerate
  assign w_blank_next = r_ovf ? '0 : w_lz_mask;
`else
  assign w_blank_next = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_bin         <= '0;
      r_bcd         <= '0;
      r_cnt         <= '0;
      r_ovf         <= 1'b0;
      r_digits      <= '0;
      r_blank       <= RST_MASK;
      r_overflow    <= 1'b0;
      r_update_done <= 1'b0;
    end else begin
      r_update_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bin <= bus.in_value;
            r_cnt <= CNT_W'(BIN_W - 1);
            if (w_over) begin
              r_bcd   <= {DIGITS{4'h9}};
              r_ovf   <= 1'b1;
              r_state <= S_UPDATE;
            end else begin
              r_bcd   <= '0;
              r_ovf   <= 1'b0;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin <= r_bin << 1;
          if (r_cnt == '0) begin
            r_state <= S_UPDATE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_UPDATE: begin
          r_digits      <= r_bcd;
          r_overflow    <= r_ovf;
          r_blank       <= w_blank_next;
          r_update_done <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.digits      = r_digits;
  assign bus.digit_blank = r_blank;
  assign bus.overflow    = r_overflow;
  assign bus.update_done = r_update_done;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Scoreboard bench for bcd_display_ctrl (BIN_W=20, DIGITS=6) with directed vectors.
// Expected blank masks follow LZ_BLANK_EN when it is defined for the build.
module tb_bcd_display_ctrl;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [23:0] d;
    logic [5:0]  b;
    logic        o;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  bcd_display_ctrl_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bcd_display_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] exp_blank(input logic [5:0] lz);
`ifdef LZ_BLANK_EN
    return lz;
`else
    return lz & 6'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per update_done pulse.
  always @(negedge clk) begin
    if (bus.update_done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_update_done: got pulse at edge %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("txn edge=%0d digits=%h blank=%b overflow=%b", cyc, bus.digits,
                 bus.digit_blank, bus.overflow);
        check("digits", 64'(bus.digits), 64'(mon_e.d));
        check("blank", 64'(bus.digit_blank), 64'(mon_e.b));
        check("overflow", 64'(bus.overflow), 64'(mon_e.o));
        check("latency_edge", 64'(cyc), 64'(mon_e.edge_n));
      end
    end
  end

  task automatic send(input logic [19:0] v, input logic [23:0] d, input logic [5:0] blz,
                      input logic o, input bit push);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready got 0 after 200 cycles, expected 1");
      return;
    end
    bus.in_value = v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{d, exp_blank(blz), o, cyc + (o ? 1 : BIN_W + 1)});
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [19:0] vals [3];
    int prev;
    int k;
    int guard;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    repeat (3) @(negedge clk);
    check("rst_digits", 64'(bus.digits), 64'h0);
    check("rst_overflow", 64'(bus.overflow), 64'h0);
    check("rst_blank", 64'(bus.digit_blank), 64'(exp_blank(6'b111110)));
    check("rst_update_done", 64'(bus.update_done), 64'h0);
    check("rst_ready", 64'(bus.in_ready), 64'h0);
    reset = 1'b0;

    // Basic conversion; outputs must hold and ready stay low during SHIFT.
    send(20'd123456, 24'h123456, 6'b000000, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("ready_low_shift", 64'(bus.in_ready), 64'h0);
    check("hold_digits", 64'(bus.digits), 64'h0);

    send(20'd0,       24'h000000, 6'b111110, 1'b0, 1'b1);
    send(20'd42,      24'h000042, 6'b111100, 1'b0, 1'b1);
    send(20'd1000,    24'h001000, 6'b110000, 1'b0, 1'b1);
    send(20'd100000,  24'h100000, 6'b000000, 1'b0, 1'b1);
    send(20'd999999,  24'h999999, 6'b000000, 1'b0, 1'b1);
    send(20'd1000000, 24'h999999, 6'b000000, 1'b1, 1'b1);
    send(20'd1048575, 24'h999999, 6'b000000, 1'b1, 1'b1);
    send(20'd9,       24'h000009, 6'b111110, 1'b0, 1'b1);

    // in_valid held high: one accept every BIN_W+2 cycles.
    vals[0] = 20'd5;
    vals[1] = 20'd6;
    vals[2] = 20'd7;
    prev  = 0;
    k     = 0;
    guard = 0;
    @(negedge clk);
    bus.in_value = vals[0];
    bus.in_valid = 1'b1;
    while (k < 3 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        sb.push_back('{24'(vals[k]), exp_blank(6'b111110), 1'b0, cyc + BIN_W + 1});
        if (k > 0) check("accept_spacing", 64'(cyc - prev), 64'd22);
        prev = cyc;
        k++;
        if (k < 3) bus.in_value = vals[k];
      end
    end
    bus.in_valid = 1'b0;
    check("stream_accepts", 64'(k), 64'd3);

    // Reset during SHIFT aborts silently.
    send(20'd123, 24'h000123, 6'b111000, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_in_reset", 64'(bus.in_ready), 64'h0);
    @(negedge clk);
    check("abort_digits", 64'(bus.digits), 64'h0);
    check("abort_overflow", 64'(bus.overflow), 64'h0);
    check("abort_blank", 64'(bus.digit_blank), 64'(exp_blank(6'b111110)));
    reset = 1'b0;
    repeat (30) @(negedge clk);
    send(20'd77, 24'h000077, 6'b111100, 1'b0, 1'b1);

    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drain", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
